// File: rtl/axi4l_master_bridge_if.sv
// AXI4-lite channel bundle shared by the bridge (Master side) and the
// downstream slave-to-parallel peripheral stage (Slave side).
interface AXI4bus #(
    parameter int dw = 32,
    parameter int aw = 32,
    parameter int sw = dw / 8
);
    logic [aw-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [dw-1:0] wdata;
    logic [sw-1:0] wstrb;
    logic          wvalid;
    logic          wready;
    logic          bvalid;
    logic [1:0]    bresp;
    logic          bready;
    logic [aw-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic          rvalid;
    logic [1:0]    rresp;
    logic [dw-1:0] rdata;
    logic          rready;

    modport Master (
        output awaddr, wdata, wstrb, awvalid, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
    );

    modport Slave (
        input  awaddr, wdata, wstrb, awvalid, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
    );
endinterface

// File: rtl/axi4l_master_bridge.sv
// Single-outstanding request/response bus to AXI4-lite master bridge.
// One transaction in flight; completion returned as a one-cycle rsp pulse.
module axi4l_master_bridge #(
    parameter int dw = 32,
    parameter int aw = 32,
    parameter int sw = dw / 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [aw-1:0] req_addr,
    input  logic [dw-1:0] req_wdata,
    input  logic [sw-1:0] req_be,
    output logic          rsp_valid,
    output logic [dw-1:0] rsp_rdata,
    output logic          rsp_err,
    AXI4bus.Master        m
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [aw-1:0] addr_q, addr_d;
    logic [dw-1:0] wdata_q, wdata_d;
    logic [sw-1:0] wstrb_q, wstrb_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          bready_q, bready_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic          b_done_q, b_done_d;
    logic          ar_done_q, ar_done_d;
    logic          r_done_q, r_done_d;
    logic          resp_err_q, resp_err_d;
    logic [dw-1:0] rdata_q, rdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [dw-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic unused_resp_lsb;

    assign aw_hs = awvalid_q & m.awready;
    assign w_hs  = wvalid_q  & m.wready;
    assign b_hs  = bready_q  & m.bvalid;
    assign ar_hs = arvalid_q & m.arready;
    assign r_hs  = rready_q  & m.rvalid;

    // Only resp[1] (SLVERR/DECERR) is reported upstream.
    assign unused_resp_lsb = m.bresp[0] ^ m.rresp[0];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        b_done_d    = b_done_q;
        ar_done_d   = ar_done_q;
        r_done_d    = r_done_q;
        resp_err_d  = resp_err_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_be;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    b_done_d  = 1'b0;
                    ar_done_d = 1'b0;
                    r_done_d  = 1'b0;
                    if (req_we) begin
                        state_d   = WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                    end else begin
                        state_d   = READ;
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                    end
                end
            end

            WRITE: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // B is accepted at any point in WRITE so early-responding slaves still complete.
                if (b_hs) begin
                    b_done_d   = 1'b1;
                    resp_err_d = m.bresp[1];
                end
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs) && (b_done_q | b_hs)) begin
                    state_d     = IDLE;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = b_hs ? m.bresp[1] : resp_err_q;
                end
            end

            READ: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    ar_done_d = 1'b1;
                end
                if (r_hs) begin
                    rready_d   = 1'b0;
                    r_done_d   = 1'b1;
                    rdata_d    = m.rdata;
                    resp_err_d = m.rresp[1];
                end
                if ((ar_done_q | ar_hs) && (r_done_q | r_hs)) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = r_hs ? m.rdata : rdata_q;
                    rsp_err_d   = r_hs ? m.rresp[1] : resp_err_q;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            b_done_q    <= 1'b0;
            ar_done_q   <= 1'b0;
            r_done_q    <= 1'b0;
            resp_err_q  <= 1'b0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            b_done_q    <= b_done_d;
            ar_done_q   <= ar_done_d;
            r_done_q    <= r_done_d;
            resp_err_q  <= resp_err_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    assign m.awaddr  = addr_q;
    assign m.araddr  = addr_q;
    assign m.wdata   = wdata_q;
    assign m.wstrb   = wstrb_q;
    assign m.awvalid = awvalid_q;
    assign m.wvalid  = wvalid_q;
    assign m.bready  = bready_q;
    assign m.arvalid = arvalid_q;
    assign m.rready  = rready_q;

endmodule

// File: tb/tb_axi4l_master_bridge.sv
// Directed + randomized bench for axi4l_master_bridge: a pulse-driven slave
// with per-channel ready/valid cycles and a cycle-count latency model.
module tb_axi4l_master_bridge;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;

    AXI4bus #(.dw(32), .aw(32), .sw(4)) bus ();

    axi4l_master_bridge #(.dw(32), .aw(32), .sw(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .m         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic slave_idle();
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rresp = 2'b00; bus.rdata = '0;
    endtask

    // Slave channel events, counted in cycles after accept (cycle 1 = first cycle
    // with valids up). Write: ka=awready, kw=wready, kb=bvalid. Read: ka=arready,
    // kb=rvalid. Each is a one-cycle pulse. Completion is the cycle of the last
    // handshake; the response pulse follows one cycle later.
    task automatic do_txn(input string name, input bit we, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be,
                          input int ka, input int kw, input int kb,
                          input logic [1:0] resp, input logic [31:0] rdat, input bit b2b);
        int exp_cyc, rcyc, npulse, nav, nwv, nbr, nar, nrr;
        bit stable, rdy_at_rsp, err_seen;
        logic [31:0] rd_seen;
        exp_cyc = (we ? max2(max2(ka, kw), kb) : max2(ka, kb)) + 1;
        rcyc = 0; npulse = 0; nav = 0; nwv = 0; nbr = 0; nar = 0; nrr = 0;
        stable = 1'b1; rdy_at_rsp = 1'b0; err_seen = 1'b0; rd_seen = '0;

        chk({name, " req_ready before accept"}, req_ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data; req_be = be;
        @(posedge clk);
        for (int k = 1; k <= exp_cyc + 3; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (bus.awvalid) nav++;
            if (bus.wvalid)  nwv++;
            if (bus.bready)  nbr++;
            if (bus.arvalid) nar++;
            if (bus.rready)  nrr++;
            if (we) begin
                if (bus.awaddr !== addr || bus.wdata !== data || bus.wstrb !== be) stable = 1'b0;
            end else begin
                if (bus.araddr !== addr) stable = 1'b0;
            end
            if (rsp_valid) begin
                npulse++;
                if (npulse == 1) begin
                    rcyc = k; err_seen = rsp_err; rd_seen = rsp_rdata; rdy_at_rsp = req_ready;
                end
            end
            bus.awready = we && (k == ka);
            bus.wready  = we && (k == kw);
            bus.bvalid  = we && (k == kb);
            bus.bresp   = resp;
            bus.arready = !we && (k == ka);
            bus.rvalid  = !we && (k == kb);
            bus.rresp   = resp;
            bus.rdata   = rdat;
            if (b2b && npulse > 0) break;
        end
        slave_idle();

        chk({name, " rsp pulses"}, npulse, 1);
        chk({name, " rsp cycle"}, rcyc, exp_cyc);
        chk({name, " rsp_err"}, err_seen, resp[1]);
        chk({name, " rsp_rdata"}, rd_seen, we ? 32'h0 : rdat);
        chk({name, " req_ready at rsp"}, rdy_at_rsp, 1);
        chk({name, " addr/data stable"}, stable, 1);
        if (we) begin
            chk({name, " awvalid cycles"}, nav, ka);
            chk({name, " wvalid cycles"}, nwv, kw);
            chk({name, " bready cycles"}, nbr, exp_cyc - 1);
            chk({name, " no read activity"}, nar + nrr, 0);
        end else begin
            chk({name, " arvalid cycles"}, nar, ka);
            chk({name, " rready cycles"}, nrr, kb);
            chk({name, " no write activity"}, nav + nwv + nbr, 0);
        end
    endtask

    bit          r_we;
    bit          r_b2b;
    int          r_ka, r_kw, r_kb, npost;
    logic [31:0] r_addr, r_data, r_rdat;
    logic [3:0]  r_be;
    logic [1:0]  r_resp;

    initial begin
        rst = 1'b1;
        req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_be = 4'($urandom);
        bus.awready = 1'($urandom); bus.wready = 1'($urandom); bus.bvalid = 1'($urandom);
        bus.bresp = 2'($urandom); bus.arready = 1'($urandom); bus.rvalid = 1'($urandom);
        bus.rresp = 2'($urandom); bus.rdata = $urandom;

        // Reset held two cycles with random inputs
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("reset valids/readies",
                {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 0);
            chk("reset addr/data/strb", {bus.awaddr, bus.araddr, bus.wdata, bus.wstrb}, 0);
            chk("reset rsp", {rsp_valid, rsp_rdata, rsp_err}, 0);
            chk("reset req_ready", req_ready, 0);
            req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = $urandom;
            bus.bvalid = 1'($urandom); bus.rvalid = 1'($urandom);
        end
        rst = 1'b0;
        req_valid = 1'b0;
        slave_idle();
        #1;
        chk("req_ready after reset", req_ready, 1);

        do_txn("wr zero-wait", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 1, 2, 2'b00, 32'h0, 1'b1);
        do_txn("wr aw-delay", 1'b1, 32'h10, 32'hCAFEF00D, 4'h3, 4, 1, 5, 2'b00, 32'h0, 1'b0);
        do_txn("rd 0x20", 1'b0, 32'h20, 32'h0, 4'h0, 1, 0, 2, 2'b10, 32'h12345678, 1'b0);
        do_txn("wr noncompliant", 1'b1, 32'h44, 32'hA5A5A5A5, 4'h9, 2, 2, 2, 2'b00, 32'h0, 1'b0);
        do_txn("wr early-b slverr", 1'b1, 32'h48, 32'h01020304, 4'hC, 3, 2, 1, 2'b10, 32'h0, 1'b0);
        do_txn("rd min-latency", 1'b0, 32'h24, 32'h0, 4'h0, 1, 0, 1, 2'b00, 32'h0BADF00D, 1'b0);

        // Reset while AW is stalled
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h80; req_wdata = 32'h55AA55AA; req_be = 4'hF;
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            bus.wready = (k == 1);
        end
        chk("stall awvalid held", bus.awvalid, 1);
        bus.wready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid-reset aw/w/b", {bus.awvalid, bus.wvalid, bus.bready}, 0);
        chk("mid-reset rsp_valid", rsp_valid, 0);
        rst = 1'b0;
        npost = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rsp_valid) npost++;
        end
        chk("no rsp for aborted txn", npost, 0);
        do_txn("rd after reset", 1'b0, 32'h4, 32'h0, 4'h0, 1, 0, 2, 2'b00, 32'h600DCAFE, 1'b0);

        for (int i = 0; i < 12; i++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_b2b  = 1'($urandom_range(0, 1));
            r_ka   = $urandom_range(1, 4);
            r_kw   = $urandom_range(1, 4);
            r_kb   = $urandom_range(1, 5);
            r_addr = $urandom & 32'hFFFF_FFFC;
            r_data = $urandom;
            r_rdat = $urandom;
            r_be   = 4'($urandom_range(0, 15));
            r_resp = 2'($urandom_range(0, 3));
            do_txn("random", r_we, r_addr, r_data, r_be, r_ka, r_kw, r_kb, r_resp, r_rdat, r_b2b);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
